pipeline_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage pipeline's PC and inter-stage enabled registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates per-stage enable and synchronous-flush strobes for load-use stalls, taken-branch flushes and multi-cycle data-memory waits.
- Watchdogs memory waits with a timeout that halts the pipeline.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 75 +++++++
 rtl/pipeline_hazard_ctrl_hazard_detect_unit.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller, the decoder and the forwarding unit.
package pipeline_hazard_ctrl_pkg;

  // Register-specifier width used across the decode/forwarding datapath.
  localparam int DEFAULT_REG_ADDR_W = 5;

  // Register index that is hardwired to zero and therefore never creates a dependency.
  localparam int ZERO_REG = 0;

  // Sequencer states: normal flow, waiting on data memory, and the terminal timeout state.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } ctrl_state_e;

  // Hazard classes in rising priority order.
  typedef enum logic [1:0] {
    HZ_NONE      = 2'd0,
    HZ_LOAD_USE  = 2'd1,
    HZ_BRANCH    = 2'd2,
    HZ_MEM_STALL = 2'd3
  } hazard_e;

  // Enable/flush strobes for the PC and the four inter-stage registers.
  typedef struct packed {
    logic pcEn;
    logic ifIdEn;
    logic ifIdFlush;
    logic idExEn;
    logic idExFlush;
    logic exMemEn;
    logic memWbEn;
  } stage_ctrl_t;

  // Picks the single hazard that governs this cycle; a memory stall freezes everything,
  // and a taken branch outranks load-use because the dependent ID instruction is squashed.
  function automatic hazard_e classifyHazard(input logic memStall,
                                             input logic branchTaken,
                                             input logic loadUse);
    hazard_e hz;
    if (memStall)         hz = HZ_MEM_STALL;
    else if (branchTaken) hz = HZ_BRANCH;
    else if (loadUse)     hz = HZ_LOAD_USE;
    else                  hz = HZ_NONE;
    return hz;
  endfunction

  // Translates a hazard class into the stage strobes that resolve it.
  function automatic stage_ctrl_t decodeHazard(input hazard_e hz);
    stage_ctrl_t ctrl;
    ctrl = '{default: 1'b0};
    case (hz)
      HZ_MEM_STALL: ctrl = '{default: 1'b0};
      HZ_BRANCH: begin
        ctrl = '{default: 1'b1};
      end
      HZ_LOAD_USE: begin
        ctrl.idExEn    = 1'b1;
        ctrl.idExFlush = 1'b1;
        ctrl.exMemEn   = 1'b1;
        ctrl.memWbEn   = 1'b1;
      end
      default: begin
        ctrl.pcEn    = 1'b1;
        ctrl.ifIdEn  = 1'b1;
        ctrl.idExEn  = 1'b1;
        ctrl.exMemEn = 1'b1;
        ctrl.memWbEn = 1'b1;
      end
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect_unit.sv
// Combinational load-use detector: a load in EX whose destination is read by the ID instruction.
module hazard_detect_unit
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] i_idRs,
  input  logic [REG_ADDR_W-1:0] i_idRt,
  input  logic                  i_idUsesRt,
  input  logic                  i_exMemRead,
  input  logic [REG_ADDR_W-1:0] i_exRt,
  output logic                  o_loadUse
);

  logic w_destValid;
  logic w_rsMatch;
  logic w_rtMatch;

  assign w_destValid = i_exMemRead && (i_exRt != REG_ADDR_W'(ZERO_REG));
  assign w_rsMatch   = (i_exRt == i_idRs);
  assign w_rtMatch   = i_idUsesRt && (i_exRt == i_idRt);
  assign o_loadUse   = w_destValid && (w_rsMatch || w_rtMatch);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central PC / pipeline-register sequencer: stalls, flushes, memory-wait watchdog and stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int MAX_WAIT   = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  halted,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int WAIT_W = $clog2(MAX_WAIT) + 1;

  ctrl_state_e       r_state;
  logic [WAIT_W-1:0] r_waitCnt;
  logic              r_halted;
  logic [CNT_W-1:0]  r_stallCount;

  ctrl_state_e       w_nextState;
  logic [WAIT_W-1:0] w_nextWaitCnt;
  logic              w_nextHalted;
  logic              w_loadUse;
  logic              w_memStall;
  hazard_e           w_hazard;
  stage_ctrl_t       w_ctrl;

  hazard_detect_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazardDetect (
    .i_idRs      (id_rs),
    .i_idRt      (id_rt),
    .i_idUsesRt  (id_uses_rt),
    .i_exMemRead (ex_mem_read),
    .i_exRt      (ex_rt),
    .o_loadUse   (w_loadUse)
  );

  assign w_memStall = mem_req && !mem_ready;

  // Next-state and stage-strobe decode; reset forces every stage frozen and flushed.
  always_comb begin
    w_nextState   = r_state;
    w_nextWaitCnt = r_waitCnt;
    w_nextHalted  = r_halted;
    w_hazard      = HZ_NONE;
    w_ctrl        = '{default: 1'b0};
    case (r_state)
      ST_RUN: begin
        w_hazard = classifyHazard(w_memStall, branch_taken, w_loadUse);
        w_ctrl   = decodeHazard(w_hazard);
        if (w_memStall) begin
          w_nextState   = ST_MEM_WAIT;
          w_nextWaitCnt = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        w_hazard = classifyHazard(w_memStall, branch_taken, w_loadUse);
        w_ctrl   = decodeHazard(w_hazard);
        if (!w_memStall) begin
          w_nextState   = ST_RUN;
          w_nextWaitCnt = '0;
        end else if (r_waitCnt == WAIT_W'(MAX_WAIT - 1)) begin
          w_nextState  = ST_HALT;
          w_nextHalted = 1'b1;
        end else begin
          w_nextWaitCnt = r_waitCnt + WAIT_W'(1);
        end
      end
      ST_HALT: begin
        w_ctrl = '{default: 1'b0};
      end
      default: begin
        w_nextState   = ST_RUN;
        w_nextWaitCnt = '0;
      end
    endcase
    if (!reset) begin
      w_ctrl           = '{default: 1'b0};
      w_ctrl.ifIdFlush = 1'b1;
      w_ctrl.idExFlush = 1'b1;
    end
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_RUN;
      r_waitCnt <= '0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWaitCnt;
      r_halted  <= w_nextHalted;
    end
  end

  // Saturating count of cycles where the PC was held, excluding the halted state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stallCount <= '0;
    end else if ((r_state != ST_HALT) && !w_ctrl.pcEn && (r_stallCount != '1)) begin
      r_stallCount <= r_stallCount + CNT_W'(1);
    end
  end

  assign pc_en       = w_ctrl.pcEn;
  assign if_id_en    = w_ctrl.ifIdEn;
  assign if_id_flush = w_ctrl.ifIdFlush;
  assign id_ex_en    = w_ctrl.idExEn;
  assign id_ex_flush = w_ctrl.idExFlush;
  assign ex_mem_en   = w_ctrl.exMemEn;
  assign mem_wb_en   = w_ctrl.memWbEn;
  assign halted      = r_halted;
  assign mem_timeout = r_halted;
  assign stall_count = r_stallCount;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int MAX_WAIT = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] idRs = '0, idRt = '0, exRt = '0;
  logic       idUsesRt = 1'b0, exMemRead = 1'b0, branchTaken = 1'b0;
  logic       memReq = 1'b0, memReady = 1'b0;

  logic        pcEn, ifIdEn, ifIdFlush, idExEn, idExFlush, exMemEn, memWbEn, haltedO, memTimeout;
  logic [15:0] stallCount;
  logic        sPcEn, sIfIdEn, sIfIdFlush, sIdExEn, sIdExFlush, sExMemEn, sMemWbEn, sHalted, sMemTimeout;
  logic [3:0]  sStallCount;

  int     checkCount = 0;
  int     failCount  = 0;
  bit     checkEnable = 0;
  bit     mHalted = 0;
  int     mWaitRun = 0;
  longint mStalls = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MAX_WAIT(MAX_WAIT), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt),
    .ex_mem_read(exMemRead), .ex_rt(exRt), .branch_taken(branchTaken),
    .mem_req(memReq), .mem_ready(memReady),
    .pc_en(pcEn), .if_id_en(ifIdEn), .if_id_flush(ifIdFlush), .id_ex_en(idExEn),
    .id_ex_flush(idExFlush), .ex_mem_en(exMemEn), .mem_wb_en(memWbEn),
    .halted(haltedO), .mem_timeout(memTimeout), .stall_count(stallCount)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MAX_WAIT(MAX_WAIT), .CNT_W(4)) dutSat (
    .clock(clock), .reset(reset), .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt),
    .ex_mem_read(exMemRead), .ex_rt(exRt), .branch_taken(branchTaken),
    .mem_req(memReq), .mem_ready(memReady),
    .pc_en(sPcEn), .if_id_en(sIfIdEn), .if_id_flush(sIfIdFlush), .id_ex_en(sIdExEn),
    .id_ex_flush(sIdExFlush), .ex_mem_en(sExMemEn), .mem_wb_en(sMemWbEn),
    .halted(sHalted), .mem_timeout(sMemTimeout), .stall_count(sStallCount)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs just after a rising edge and returns at the following falling edge.
  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                               input logic memRead, input logic [4:0] dst, input logic br,
                               input logic req, input logic ready);
    @(posedge clock);
    #1;
    reset       = 1'b1;
    idRs        = rs;
    idRt        = rt;
    idUsesRt    = usesRt;
    exMemRead   = memRead;
    exRt        = dst;
    branchTaken = br;
    memReq      = req;
    memReady    = ready;
    @(negedge clock);
  endtask

  // Holds reset low for one cycle with idle inputs and pins the reset-time outputs.
  task automatic doReset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    {idRs, idRt, exRt} = '0;
    {idUsesRt, exMemRead, branchTaken, memReq, memReady} = '0;
    @(negedge clock);
    checkOutput("rst_pc_en", pcEn, 0);
    checkOutput("rst_if_id_flush", ifIdFlush, 1);
    checkOutput("rst_id_ex_flush", idExFlush, 1);
    checkOutput("rst_halted", haltedO, 0);
    checkOutput("rst_stall_count", stallCount, 0);
  endtask

  // Per-cycle comparison against the behavioural model; the model then advances by one cycle.
  always @(negedge clock) begin
    bit       lu, ms;
    bit [6:0] expCtrl, actCtrl, actSat;
    longint   expCnt, expSat;
    if (checkEnable) begin
      if (!reset) begin
        mHalted  = 0;
        mWaitRun = 0;
        mStalls  = 0;
      end
      ms = memReq && !memReady;
      lu = exMemRead && (exRt != 0) && ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
      // Bit order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en.
      if (!reset)           expCtrl = 7'b0010100;
      else if (mHalted)     expCtrl = 7'b0000000;
      else if (ms)          expCtrl = 7'b0000000;
      else if (branchTaken) expCtrl = 7'b1111111;
      else if (lu)          expCtrl = 7'b0001111;
      else                  expCtrl = 7'b1101011;
      actCtrl = {pcEn, ifIdEn, ifIdFlush, idExEn, idExFlush, exMemEn, memWbEn};
      actSat  = {sPcEn, sIfIdEn, sIfIdFlush, sIdExEn, sIdExFlush, sExMemEn, sMemWbEn};
      expCnt  = (mStalls > 65535) ? 65535 : mStalls;
      expSat  = (mStalls > 15) ? 15 : mStalls;
      checkOutput("model_stage_ctrl", actCtrl, expCtrl);
      checkOutput("model_stage_ctrl_sat", actSat, expCtrl);
      checkOutput("model_halted", haltedO, mHalted);
      checkOutput("model_mem_timeout", memTimeout, mHalted);
      checkOutput("model_sat_halted", sHalted, mHalted);
      checkOutput("model_stall_count", stallCount, expCnt);
      checkOutput("model_stall_count_sat", sStallCount, expSat);
      if (reset && !mHalted) begin
        if (!expCtrl[6]) mStalls++;
        if (ms) begin
          mWaitRun++;
          if (mWaitRun >= MAX_WAIT) mHalted = 1;
        end else begin
          mWaitRun = 0;
        end
      end
    end
  end

  initial begin
    int readyPct;
    #2;
    reset = 1'b0;
    checkEnable = 1;
    @(negedge clock);
    $display("[TB] directed scenarios");

    doReset();
    applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_pc_en", pcEn, 0);
    checkOutput("lu_if_id_en", ifIdEn, 0);
    checkOutput("lu_id_ex_flush", idExFlush, 1);
    checkOutput("lu_count_before", stallCount, 0);
    applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_count_after", stallCount, 1);
    checkOutput("lu_next_pc_en", pcEn, 1);
    checkOutput("lu_next_id_ex_en", idExEn, 1);

    applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("zero_pc_en", pcEn, 1);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("zero_count", stallCount, 1);

    applyStimulus(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    checkOutput("br_lu_pc_en", pcEn, 1);
    checkOutput("br_lu_if_id_flush", ifIdFlush, 1);
    checkOutput("br_lu_id_ex_flush", idExFlush, 1);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("br_lu_count", stallCount, 1);

    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("wait_pc_en", pcEn, 0);
      checkOutput("wait_mem_wb_en", memWbEn, 0);
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("wait_ready_pc_en", pcEn, 1);
    checkOutput("wait_ready_mem_wb_en", memWbEn, 1);
    checkOutput("wait_count", stallCount, 3);

    doReset();
    for (int i = 0; i < MAX_WAIT; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("to_not_yet_halted", haltedO, 0);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("to_halted", haltedO, 1);
    checkOutput("to_mem_timeout", memTimeout, 1);
    checkOutput("to_pc_en", pcEn, 0);
    checkOutput("to_ex_mem_en", exMemEn, 0);
    checkOutput("to_count", stallCount, 16);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("to_count_frozen", stallCount, 16);
    checkOutput("to_if_id_flush", ifIdFlush, 0);
    doReset();
    checkOutput("to_reset_timeout", memTimeout, 0);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("to_resumed_pc_en", pcEn, 1);

    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_count_4bit", sStallCount, 15);
    checkOutput("sat_count_16bit", stallCount, 20);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      readyPct = (((i / 400) % 3) == 2) ? 8 : 60;
      @(posedge clock);
      #1;
      reset       = ($urandom_range(0, 299) != 0);
      idRs        = 5'($urandom_range(0, 3));
      idRt        = 5'($urandom_range(0, 3));
      exRt        = 5'($urandom_range(0, 3));
      idUsesRt    = 1'($urandom_range(0, 1));
      exMemRead   = ($urandom_range(0, 99) < 50);
      branchTaken = ($urandom_range(0, 99) < 20);
      memReq      = ($urandom_range(0, 99) < 40);
      memReady    = ($urandom_range(0, 99) < readyPct);
    end
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
